// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the three-port memory arbiter.
package mem_port_arbiter_pkg;
  localparam int AW_DEF           = 16;
  localparam int DW_DEF           = 16;
  localparam int STARVE_LIMIT_DEF = 15;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_DATA  = 2'b01;
  localparam logic [1:0] GNT_FETCH = 2'b10;
  localparam logic [1:0] GNT_LOAD  = 2'b11;
endpackage

// File: rtl/mem_arb_priority.sv
// Winner select: data > fetch > loader, loader forced when it has starved.
module mem_arb_priority
  import mem_port_arbiter_pkg::*;
(
  input  logic       d_req,
  input  logic       f_req,
  input  logic       l_req,
  input  logic       starve,
  output logic [1:0] grant
);
  always_comb begin
    grant = GNT_NONE;
    if (l_req && starve) grant = GNT_LOAD;
    else if (d_req)      grant = GNT_DATA;
    else if (f_req)      grant = GNT_FETCH;
    else if (l_req)      grant = GNT_LOAD;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates data, fetch and loader ports onto one RAM with a fixed
// four-cycle IDLE/ACCESS/WAIT/DONE access sequence.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy,
  output logic [1:0]    grant_id
);
  state_t        state, state_nxt;
  logic [7:0]    starve_cnt;
  logic          starve, any_req;
  logic [1:0]    winner;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_we;

  assign any_req = d_req | f_req | l_req;
  assign starve  = (starve_cnt == 8'(STARVE_LIMIT));

  mem_arb_priority u_prio (
    .d_req  (d_req),
    .f_req  (f_req),
    .l_req  (l_req),
    .starve (starve),
    .grant  (winner)
  );

  // Fetch is read-only, so it leaves ram_data as it was.
  always_comb begin
    sel_addr = f_addr;
    sel_data = ram_data;
    sel_we   = 1'b0;
    case (winner)
      GNT_DATA: begin sel_addr = d_addr; sel_data = d_wdata; sel_we = d_we; end
      GNT_LOAD: begin sel_addr = l_addr; sel_data = l_wdata; sel_we = l_we; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    d_ack     = 1'b0;
    f_ack     = 1'b0;
    l_ack     = 1'b0;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        d_ack     = (grant_id == GNT_DATA);
        f_ack     = (grant_id == GNT_FETCH);
        l_ack     = (grant_id == GNT_LOAD);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      rdata       <= '0;
      grant_id    <= GNT_NONE;
      starve_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!l_req) starve_cnt <= 8'd0;
          if (any_req) begin
            grant_id    <= winner;
            ram_address <= sel_addr;
            ram_data    <= sel_data;
            ram_wren    <= sel_we;
            // Only loses with l_req high count toward starvation.
            if (winner == GNT_LOAD)  starve_cnt <= 8'd0;
            else if (l_req && !starve) starve_cnt <= starve_cnt + 8'd1;
          end
        end
        ACCESS: ram_wren <= 1'b0;
        WAIT:   rdata    <= ram_q;
        DONE:   grant_id <= GNT_NONE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int LIM = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, d_req, d_we, f_req, l_req, l_we;
  logic [15:0] d_addr, d_wdata, f_addr, l_addr, l_wdata;
  logic        d_ack, f_ack, l_ack, ram_wren, busy;
  logic [15:0] rdata, ram_address, ram_data, ram_q;
  logic [1:0]  grant_id;

  mem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [15:0] init_val(logic [7:0] a);
    return (a == 8'd5) ? 16'h1234 : {a, ~a};
  endfunction

  // RAM: registered address, combinational q.
  logic [15:0] mem [256];
  logic [7:0]  raddr_q;
  logic        filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      filled <= 1'b1;
    end else if (ram_wren) mem[ram_address[7:0]] <= ram_data;
    raddr_q <= ram_address[7:0];
  end
  assign ram_q = mem[raddr_q];

  // Reference model: one access slot; cycles since the winning sample.
  int          total = 0, bad = 0;
  int          m_ph = 0, m_cnt = 0;
  logic [1:0]  m_gnt = 2'b00;
  logic [15:0] m_rdata = '0, m_addr = '0, m_data = '0;
  logic        m_we = 1'b0;
  logic [15:0] mmem [256];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int w;
    if (m_ph == 1 && m_we) mmem[m_addr[7:0]] = m_data;
    if (!rst_n) begin
      m_ph = 0; m_cnt = 0; m_gnt = 2'b00; m_rdata = '0;
      m_addr = '0; m_data = '0; m_we = 1'b0;
    end else if (m_ph == 0) begin
      if (!l_req) m_cnt = 0;
      if (d_req || f_req || l_req) begin
        if (l_req && m_cnt == LIM) w = 3;
        else if (d_req)            w = 1;
        else if (f_req)            w = 2;
        else                       w = 3;
        m_gnt = 2'(w);
        if (w == 3)     m_cnt = 0;
        else if (l_req) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
        if (w == 1)      begin m_addr = d_addr; m_data = d_wdata; m_we = d_we; end
        else if (w == 2) begin m_addr = f_addr; m_we = 1'b0; end
        else             begin m_addr = l_addr; m_data = l_wdata; m_we = l_we; end
        m_ph = 1;
      end
    end else if (m_ph == 2) begin
      m_rdata = mmem[m_addr[7:0]];
      m_ph = 3;
    end else begin
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  task automatic check_all();
    chk("busy",        32'(busy),        32'(m_ph != 0));
    chk("grant_id",    32'(grant_id),    32'((m_ph != 0) ? m_gnt : 2'b00));
    chk("ram_wren",    32'(ram_wren),    32'(m_ph == 1 && m_we));
    chk("ram_address", 32'(ram_address), 32'(m_addr));
    chk("ram_data",    32'(ram_data),    32'(m_data));
    chk("d_ack",       32'(d_ack),       32'(m_ph == 3 && m_gnt == 2'b01));
    chk("f_ack",       32'(f_ack),       32'(m_ph == 3 && m_gnt == 2'b10));
    chk("l_ack",       32'(l_ack),       32'(m_ph == 3 && m_gnt == 2'b11));
    chk("rdata",       32'(rdata),       32'(m_rdata));
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic ack_of(int which);
    case (which)
      1:       return d_ack;
      2:       return f_ack;
      3:       return l_ack;
      default: return d_ack | f_ack | l_ack;
    endcase
  endfunction

  task automatic wait_ack(input int which, input int maxc, output int n, output logic got);
    n = 0; got = 1'b0;
    while (!got && n < maxc) begin
      cyc();
      n++;
      got = ack_of(which);
    end
  endtask

  initial begin
    int   n, others;
    logic got;
    logic dp, fp, lp;
    for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
    rst_n = 1'b0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_req = 0; f_addr = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;

    // Fetch of preloaded word
    f_req = 1; f_addr = 16'h0005;
    cyc();
    chk("t1_grant", 32'(grant_id), 32'(GNT_FETCH));
    f_req = 1'b0;
    cyc(); cyc();
    chk("t1_f_ack", 32'(f_ack), 32'd1);
    chk("t1_rdata", 32'(rdata), 32'h1234);
    cyc();

    // Data write then fetch it back
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    cyc();
    chk("t2_wren", 32'(ram_wren), 32'd1);
    chk("t2_addr", 32'(ram_address), 32'h0040);
    chk("t2_data", 32'(ram_data), 32'hBEEF);
    cyc();
    chk("t2_wren_off", 32'(ram_wren), 32'd0);
    cyc();
    chk("t2_d_ack", 32'(d_ack), 32'd1);
    d_req = 0; d_we = 0;
    cyc();
    f_req = 1; f_addr = 16'h0040;
    wait_ack(2, 8, n, got);
    chk("t2_f_ack", 32'(got), 32'd1);
    chk("t2_rback", 32'(rdata), 32'hBEEF);
    f_req = 0;
    cyc();

    // Data beats fetch; fetch follows four cycles later
    d_req = 1; d_addr = 16'h0007; f_req = 1; f_addr = 16'h0009;
    wait_ack(1, 8, n, got);
    chk("t3_d_ack", 32'(got), 32'd1);
    chk("t3_d_lat", 32'(n), 32'd3);
    d_req = 0;
    wait_ack(2, 8, n, got);
    chk("t3_f_ack", 32'(got), 32'd1);
    chk("t3_f_gap", 32'(n), 32'd4);
    f_req = 0;
    cyc();

    // Loader starvation with data/fetch alternating
    l_req = 1; l_we = 0; l_addr = 16'h0003; d_req = 1; d_addr = 16'h0001; f_addr = 16'h0002;
    others = 0;
    for (int k = 0; k < 20; k++) begin
      wait_ack(0, 8, n, got);
      if (!got || l_ack) break;
      others++;
      if (d_ack) begin d_req = 0; f_req = 1; end
      else       begin f_req = 0; d_req = 1; end
    end
    chk("t4_l_ack", 32'(l_ack), 32'd1);
    chk("t4_losses", 32'(others), 32'(LIM));
    l_req = 0; d_req = 0; f_req = 0;
    cyc();

    // Reset during a write access
    d_req = 1; d_we = 1; d_addr = 16'h0022; d_wdata = 16'hCAFE;
    cyc();
    chk("t5_wren", 32'(ram_wren), 32'd1);
    rst_n = 0; d_req = 0; d_we = 0;
    cyc();
    chk("t5_wren_off", 32'(ram_wren), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(grant_id), 32'd0);
    chk("t5_d_ack", 32'(d_ack), 32'd0);
    rst_n = 1;
    cyc(); cyc(); cyc(); cyc();

    // Held fetch repeats every four cycles
    f_req = 1; f_addr = 16'h0011;
    wait_ack(2, 8, n, got);
    chk("t6_first", 32'(n), 32'd3);
    wait_ack(2, 8, n, got);
    chk("t6_second", 32'(n), 32'd4);
    wait_ack(2, 8, n, got);
    chk("t6_third", 32'(n), 32'd4);
    chk("t6_rdata", 32'(rdata), 32'(init_val(8'h11)));
    f_req = 0;
    cyc();

    // Random traffic; each requester holds until its ack
    dp = 0; fp = 0; lp = 0;
    for (int c = 0; c < 600; c++) begin
      if (!dp || d_ack) begin
        dp = ($urandom_range(0, 2) == 0);
        d_we = 1'($urandom); d_addr = 16'($urandom_range(0, 31)); d_wdata = 16'($urandom);
      end
      if (!fp || f_ack) begin
        fp = ($urandom_range(0, 2) == 0);
        f_addr = 16'($urandom_range(0, 31));
      end
      if (!lp || l_ack) begin
        lp = ($urandom_range(0, 1) == 0);
        l_we = 1'($urandom); l_addr = 16'($urandom_range(0, 31)); l_wdata = 16'($urandom);
      end
      d_req = dp; f_req = fp; l_req = lp;
      if ($urandom_range(0, 199) == 0) rst_n = 0;
      else rst_n = 1;
      if (!rst_n) begin dp = 0; fp = 0; lp = 0; d_req = 0; f_req = 0; l_req = 0; end
      cyc();
    end
    rst_n = 1; d_req = 0; f_req = 0; l_req = 0;
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: AW, 16, address width of the shared RAM.
REQ-002 Parameter: DW, 16, data width of the shared RAM.
REQ-003 Parameter: STARVE_LIMIT, 15, number of lost arbitrations after which the loader port wins; legal range 1..255.
REQ-004 Ports: clk  in  1  single clock; all logic on the rising edge.
REQ-005 Ports: rst_n  in  1  reset; synchronous, active-low.
REQ-006 Ports: d_req/d_we  in  1/1  data port (load/store) request and write enable; d_addr  in  AW; d_wdata  in  DW; d_ack  out  1.
REQ-007 Ports: f_req  in  1  instruction-fetch request, read only; f_addr  in  AW; f_ack  out  1.
REQ-008 Ports: l_req/l_we  in  1/1  loader/debug request and write enable; l_addr  in  AW; l_wdata  in  DW; l_ack  out  1.
REQ-009 Ports: rdata  out  DW  read data shared by all ports, valid while the port's ack is high.
REQ-010 Ports: ram_address  out  AW; ram_data  out  DW; ram_wren  out  1; ram_q  in  DW  (RAM has registered address, unregistered q).
REQ-011 Ports: busy  out  1  high whenever state is not IDLE; grant_id  out  2  00 none, 01 data, 10 fetch, 11 loader.

Function
REQ-012 FSM states: IDLE, ACCESS, WAIT, DONE; the cycle sequence is IDLE -> ACCESS -> WAIT -> DONE -> IDLE, with no other transitions.
REQ-013 In IDLE, with any req high: pick a winner, latch its addr, wdata and we into ram_address, ram_data and ram_wren, set grant_id, and go to ACCESS on the next edge.
REQ-014 Priority: data > fetch > loader, except when the starvation counter equals STARVE_LIMIT and l_req is high; in that case the loader wins.
REQ-015 ACCESS: ram_wren is high for exactly this one cycle if the latched we=1; the RAM captures the address at the end of the cycle.
REQ-016 WAIT: ram_wren is 0; ram_q becomes valid.
REQ-017 At the end of WAIT, rdata is registered from ram_q.
REQ-018 DONE: the granted port's ack is high for exactly one cycle; rdata holds its value until the next DONE.
REQ-019 Write accesses also complete in DONE and also pulse ack; rdata then carries the value ram_q returned in WAIT.
REQ-020 Latency: ack rises 3 cycles after the IDLE cycle in which req was sampled; throughput is one access every 4 cycles.
REQ-021 Requesters hold req, addr, wdata and we stable until ack; the arbiter ignores changes after the IDLE sample.
REQ-022 A req still high in the cycle after DONE is treated as a new request.
REQ-023 Dropping req before ack does not abort the access; ack still pulses in DONE.
REQ-024 Starvation counter (8 bit): increment by 1 in each IDLE arbitration cycle where l_req=1 and another port wins; saturate at STARVE_LIMIT.
REQ-025 Starvation counter: clear to 0 when the loader is granted or when l_req=0 in IDLE.
REQ-026 ram_address and ram_data hold their last values outside ACCESS; only ram_wren gates writes.
REQ-027 At most one ack is high in any cycle; in IDLE, ACCESS and WAIT no ack is high.

Reset
REQ-028 On any clk edge with rst_n=0: state=IDLE, all acks=0, ram_wren=0, ram_address=0, ram_data=0, rdata=0, grant_id=00, starvation counter=0.
REQ-029 Reset mid-access abandons the access with no ack; a reset during ACCESS deasserts ram_wren from the following cycle.
REQ-030 Arbitration resumes on the first edge with rst_n=1.

Structure
REQ-031 The shared package holds: the state enum (IDLE/ACCESS/WAIT/DONE), the grant_id encodings, and the defaults of AW, DW and STARVE_LIMIT.
REQ-032 One sub-module: mem_arb_priority, a combinational winner select from the three reqs and the starvation flag, returning grant_id.
REQ-033 The FSM, latches and counter live in the top module.

Verification
REQ-034 Reset, then f_req=1 with f_addr=0x0005 and RAM[5]=0x1234 -> f_ack high in cycle 3 after the sample, rdata=0x1234, grant_id=10 during the access.
REQ-035 d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> ram_wren high in exactly one cycle with ram_address=0x0040 and ram_data=0xBEEF; d_ack in DONE; a later fetch from 0x0040 returns 0xBEEF.
REQ-036 d_req and f_req high in the same IDLE cycle -> data served first; fetch acked 4 cycles after d_ack.
REQ-037 l_req held high while d_req and f_req alternate continuously, STARVE_LIMIT=15 -> loader granted on the 16th arbitration; counter returns to 0.
REQ-038 rst_n=0 for one cycle during ACCESS of a write -> ram_wren=0 the next cycle, no ack, busy=0, grant_id=00.
REQ-039 f_req held high through f_ack -> a second fetch begins in the IDLE cycle after DONE and f_ack repeats every 4 cycles.
